// File: rtl/blast_seq_pkg.sv
// Shared types and elaboration helpers for the BLAST fully-connected sequencer.
package blast_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StDone
    } seq_state_e;

    // True when a score of nbits can hold a popcount of isize bits and there are
    // at least two neurons to rank.
    function automatic bit fc_widths_ok(input int unsigned isize, input int unsigned osize,
                                        input int unsigned nbits);
        return (nbits >= $clog2(isize + 1)) && (osize >= 2);
    endfunction

endpackage

// File: rtl/popcnt_hw.sv
// Combinational population count of an INPUT_WIDTH-bit vector.
module popcnt_hw #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 4
) (
    input  logic [INPUT_WIDTH-1:0]  data_i,
    output logic [OUTPUT_WIDTH-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            count_o = count_o + OUTPUT_WIDTH'(data_i[i]);
        end
    end

endmodule

// File: rtl/blast_fc_sequencer.sv
// Binary FC layer sequencer: fetches one weight row per cycle, scores it by XNOR-popcount.
// Define BLAST_SEQ_ARGMAX_EN to build the argmax tracker that drives class_o.
module blast_fc_sequencer
    import blast_seq_pkg::*;
#(
    parameter int unsigned ISIZE_FEAT = 8,
    parameter int unsigned OSIZE_FEAT = 10,
    parameter int unsigned N_BITCONV  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [ISIZE_FEAT-1:0]             layer_i,
    output logic                              weight_req_o,
    output logic [$clog2(OSIZE_FEAT)-1:0]     weight_addr_o,
    input  logic [ISIZE_FEAT-1:0]             weight_rdata_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [OSIZE_FEAT*N_BITCONV-1:0]   layer_o,
    output logic [$clog2(OSIZE_FEAT)-1:0]     class_o,
    output logic                              busy_o
);

    localparam int unsigned AW = $clog2(OSIZE_FEAT);
    localparam logic [AW-1:0] LastK = AW'(OSIZE_FEAT - 1);

    if (!fc_widths_ok(ISIZE_FEAT, OSIZE_FEAT, N_BITCONV)) begin : g_bad_params
        $error("blast_fc_sequencer: N_BITCONV too narrow or OSIZE_FEAT < 2");
    end

    seq_state_e state_q, state_d;
    logic [AW-1:0]         k_q, k_d;
    logic [ISIZE_FEAT-1:0] vec_q, vec_d;
    // strobe_q/saddr_q mark the cycle in which weight_rdata_i holds row saddr_q
    logic                  strobe_q;
    logic [AW-1:0]         saddr_q;
    logic [OSIZE_FEAT-1:0][N_BITCONV-1:0] layer_q;
    logic [N_BITCONV-1:0]  score;

    popcnt_hw #(
        .INPUT_WIDTH  (ISIZE_FEAT),
        .OUTPUT_WIDTH (N_BITCONV)
    ) u_popcnt (
        .data_i  (~(vec_q ^ weight_rdata_i)),
        .count_o (score)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        vec_d        = vec_q;
        in_ready_o   = 1'b0;
        weight_req_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    vec_d   = layer_i;
                    k_d     = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                weight_req_o = 1'b1;
                if (k_q == LastK) begin
                    k_d     = '0;
                    state_d = StWait;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            StWait: begin
                state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            k_q      <= '0;
            vec_q    <= '0;
            strobe_q <= 1'b0;
            saddr_q  <= '0;
            layer_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            vec_q    <= vec_d;
            strobe_q <= weight_req_o;
            saddr_q  <= k_q;
            if (strobe_q) begin
                layer_q[saddr_q] <= score;
            end
        end
    end

`ifdef BLAST_SEQ_ARGMAX_EN
    logic [N_BITCONV-1:0] best_q;
    logic [AW-1:0]        class_q;

    // Row 0 seeds the running maximum; later rows replace it only when strictly greater.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_q  <= '0;
            class_q <= '0;
        end else if (strobe_q && ((saddr_q == '0) || (score > best_q))) begin
            best_q  <= score;
            class_q <= saddr_q;
        end
    end

    assign class_o = class_q;
`else
    assign class_o = '0;
`endif

    assign weight_addr_o = k_q;
    assign layer_o       = layer_q;
    assign out_valid_o   = (state_q == StDone);
    assign busy_o        = (state_q != StIdle);

endmodule

// File: doc/blast_fc_sequencer.md
BLAST_FC_SEQUENCER -- requirements
Module: blast_fc_sequencer

Interface
REQ-001 SHALL have parameter ISIZE_FEAT, default 8: input feature vector width in bits.
REQ-002 SHALL have parameter OSIZE_FEAT, default 10: number of output neurons (classes).
REQ-003 SHALL have parameter N_BITCONV, default 4: bits per output score.
REQ-004 SHALL have port clk_i  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid_i  input  1: feature vector offered.
REQ-007 SHALL have port in_ready_o  output  1: sequencer can accept a vector.
REQ-008 SHALL have port layer_i  input  ISIZE_FEAT: binary feature vector.
REQ-009 SHALL have port weight_req_o  output  1: weight-row read strobe.
REQ-010 SHALL have port weight_addr_o  output  $clog2(OSIZE_FEAT): weight-row index.
REQ-011 SHALL have port weight_rdata_i  input  ISIZE_FEAT: weight row, valid one cycle after the strobe.
REQ-012 SHALL have port out_valid_o  output  1: scores and class valid.
REQ-013 SHALL have port out_ready_i  input  1: consumer accepts the result.
REQ-014 SHALL have port layer_o  output  OSIZE_FEAT x N_BITCONV: per-neuron XNOR-popcount scores.
REQ-015 SHALL have port class_o  output  $clog2(OSIZE_FEAT): argmax index.
REQ-016 SHALL have port busy_o  output  1: high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, FETCH, WAIT and DONE.
REQ-018 SHALL assert in_ready_o only in IDLE; an in_valid_i&in_ready_o edge SHALL latch layer_i and move to FETCH with counter k=0.
REQ-019 SHALL, in FETCH, drive weight_req_o=1 and weight_addr_o=k, increment k each cycle, and go to WAIT after k=OSIZE_FEAT-1.
REQ-020 SHALL, one cycle after each strobe, store score[k] = popcount(~(latched_vec ^ weight_rdata_i)) into layer_o[k].
REQ-021 SHALL capture the last score in WAIT, then enter DONE, where out_valid_o is first high in the (OSIZE_FEAT+2)-th cycle after the accept edge.
REQ-022 SHALL hold out_valid_o, layer_o and class_o stable in DONE until out_valid_o&out_ready_i, then return to IDLE.
REQ-023 SHALL keep weight_req_o=0 outside FETCH; weight_rdata_i SHALL be ignored except in the cycle after a strobe.
REQ-024 SHALL run the argmax incrementally: update only on a strictly greater score, so that ties resolve to the lowest index.
REQ-025 SHALL fail elaboration when N_BITCONV < $clog2(ISIZE_FEAT+1) or OSIZE_FEAT < 2.
REQ-026 SHALL ignore in_valid_i outside IDLE; a result SHALL never be dropped under backpressure.

Reset
REQ-027 SHALL, on rst_i, enter IDLE and set k=0, in_ready_o=1, out_valid_o=0, weight_req_o=0, busy_o=0, and layer_o and class_o to all zeros.
REQ-028 SHALL, on rst_i in any state (including mid-FETCH), abort the operation and discard partial scores; IDLE SHALL be entered on the next cycle.

Configuration
REQ-029 SHALL, with BLAST_SEQ_ARGMAX_EN defined, compile in the argmax tracker and drive class_o from it.
REQ-030 SHALL, without BLAST_SEQ_ARGMAX_EN, omit the tracker, tie class_o to 0 and leave all other timing unchanged.

Structure
REQ-031 SHALL import the state enum type and a width-check helper function from the shared package blast_seq_pkg.
REQ-032 SHALL compute the score through one instance of the existing popcnt_hw (INPUT_WIDTH=ISIZE_FEAT, OUTPUT_WIDTH=N_BITCONV).

Verification (ISIZE_FEAT=8, OSIZE_FEAT=4, N_BITCONV=4; 1-cycle weight model)
REQ-033 SHALL cover: layer_i=8'hFF, rows {FF,0F,00,F0} -> layer_o={8,4,0,4}, class_o=0, out_valid_o at cycle 6 after accept.
REQ-034 SHALL cover: layer_i=8'h0F, all rows 8'h0F -> scores {8,8,8,8}, class_o=0 (tie to the lowest index).
REQ-035 SHALL cover: out_ready_i held low 10 cycles in DONE -> outputs stable, in_ready_o=0, no weight_req_o.
REQ-036 SHALL cover: rst_i at FETCH k=2 -> next cycle IDLE, out_valid_o=0, in_ready_o=1; a fresh vector then completes correctly.
REQ-037 SHALL cover: two back-to-back vectors with out_ready_i=1 -> second accepted the cycle after the first handshake, both results correct.
REQ-038 SHALL cover: build without BLAST_SEQ_ARGMAX_EN, rows {00,FF,00,00}, layer_i=8'hFF -> class_o=0, layer_o={0,8,0,0}.
